// File: rtl/dsp_mac_pkg.sv
// Shared constants and types for the DSP48A1 MAC operand feeder.
package dsp_mac_pkg;

  localparam int DATA_W_DEF   = 18;
  localparam int ACC_W_DEF    = 48;
  localparam int CNT_W_DEF    = 8;
  localparam int PIPE_LAT_DEF = 3;

  // OPMODE encodings: [1:0] X mux, [3:2] Z mux, post-adder add, no carry-in
  localparam logic [7:0] OPM_ZERO = 8'h00;  // X=0, Z=0
  localparam logic [7:0] OPM_LOAD = 8'h01;  // X=M, Z=0 : start a new sum
  localparam logic [7:0] OPM_ACC  = 8'h09;  // X=M, Z=P : accumulate

  // Per-beat tag travelling alongside the slice pipeline
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/dsp_tag_pipe.sv
// Fixed-depth shift register of beat tags that tracks a beat through the
// slice pipeline, plus a flag telling whether any frame end is in flight.
module dsp_tag_pipe
  import dsp_mac_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT_DEF + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t i_tag,
  output tag_t o_tag,
  output logic o_last_inflight
);

  tag_t [DEPTH-1:0] r_pipe;

  // Shift one stage per edge; synchronous clear drops any in-flight frame
  always_ff @(posedge clk) begin
    if (!rst_n) r_pipe <= '0;
    else        r_pipe <= {r_pipe[DEPTH-2:0], i_tag};
  end

  // OR-reduce "valid last" over every stage
  always_comb begin
    o_last_inflight = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      o_last_inflight = o_last_inflight | (r_pipe[i].valid & r_pipe[i].last);
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/dsp_mac_feeder.sv
// Operand sequencer for a DSP48A1 slice (A1/B1/M/P/OPMODE registered):
// streams (a,b) pairs into the slice so P accumulates sum(a*b) per frame,
// then captures P into a valid/ready result port.
module dsp_mac_feeder
  import dsp_mac_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_a,
  input  logic [DATA_W-1:0] s_b,
  input  logic              s_last,
  output logic [DATA_W-1:0] dsp_a,
  output logic [DATA_W-1:0] dsp_b,
  output logic [7:0]        dsp_opmode,
  output logic              dsp_rst,
  output logic              dsp_ce,
  input  logic [ACC_W-1:0]  dsp_p,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_data,
  output logic [CNT_W-1:0]  m_count,
  output logic              m_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_accept;
  logic             w_last_inflight;
  logic             w_capture;
  tag_t             w_tag_in;
  tag_t             w_tag_out;
  logic             r_first;      // next accepted beat opens a frame
  logic             r_load_pend;  // operands just issued were a frame's first term
  logic [CNT_W-1:0] r_cnt;

  // Slice resets on the same edge as the feeder; CE held off while in reset
  assign dsp_rst = ~rst_n;
  assign dsp_ce  = rst_n;

  // Only one frame end may be in flight, and none while a result is pending
  assign s_ready  = rst_n & ~m_valid & ~w_last_inflight;
  assign w_accept = s_valid & s_ready;
  assign w_tag_in = '{valid: w_accept, last: w_accept & s_last};

  dsp_tag_pipe #(.DEPTH(PIPE_LAT + 1)) u_tag_pipe (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_tag          (w_tag_in),
    .o_tag          (w_tag_out),
    .o_last_inflight(w_last_inflight)
  );

  assign w_capture = w_tag_out.valid & w_tag_out.last;

  // Operand drive: accepted beat, otherwise a zero bubble (adds 0 to P)
  always_ff @(posedge clk) begin
    if (!rst_n || !w_accept) begin
      dsp_a <= '0;
      dsp_b <= '0;
    end else begin
      dsp_a <= s_a;
      dsp_b <= s_b;
    end
  end

  // Opmode lags operands by one edge so the slice's OPMODE reg lines up with M
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_load_pend <= 1'b0;
      dsp_opmode  <= OPM_ZERO;
    end else begin
      r_load_pend <= w_accept & r_first;
      dsp_opmode  <= r_load_pend ? OPM_LOAD : OPM_ACC;
    end
  end

  // Saturating term counter; reloads on the first beat of each frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_first <= 1'b1;
    end else if (w_accept) begin
      r_first <= s_last;
      if (r_first)              r_cnt <= CNT_W'(1);
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Capture P when the frame-end tag leaves the pipe; hold until handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_count <= '0;
      m_sat   <= 1'b0;
    end else if (w_capture) begin
      m_valid <= 1'b1;
      m_data  <= dsp_p;
      m_count <= r_cnt;
      m_sat   <= (r_cnt == CNT_MAX);
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
